// File: rtl/ps2_pkg.sv
// Shared constants, FSM state type and parity helper for the PS/2 scan-code receiver.
package ps2_pkg;
   localparam logic [7:0] BREAK_PREFIX = 8'hF0;
   localparam logic [7:0] EXT_PREFIX   = 8'hE0;
   localparam int         FRAME_BITS   = 11;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      CHECK = 2'd2
   } ps2_state_t;

   // Odd parity holds when data bits plus parity bit contain an odd number of ones.
   function automatic logic odd_parity_ok(input logic [7:0] data, input logic parity);
      return ^{data, parity};
   endfunction
endpackage

// File: rtl/ps2_clk_filter.sv
// PS/2 clock synchroniser and deglitcher; emits a one-cycle strobe on each
// filtered falling edge of the keyboard clock.
module ps2_clk_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic ps2c,
   output logic fall_edge
);
   logic [1:0]            sync_r;
   logic [FILTER_LEN-1:0] hist_r;
   logic                  filt_r;
   logic                  fall_r;

   // Synchronise, collect history and move the filtered level only on a unanimous window.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_r <= 2'b11;
         hist_r <= {FILTER_LEN{1'b1}};
         filt_r <= 1'b1;
         fall_r <= 1'b0;
      end else begin
         sync_r <= {sync_r[0], ps2c};
         hist_r <= {hist_r[FILTER_LEN-2:0], sync_r[1]};
         fall_r <= 1'b0;
         if (hist_r == {FILTER_LEN{1'b0}}) begin
            fall_r <= filt_r;
            filt_r <= 1'b0;
         end else if (hist_r == {FILTER_LEN{1'b1}}) begin
            filt_r <= 1'b1;
         end else begin
            filt_r <= filt_r;
         end
      end
   end

   assign fall_edge = fall_r;
endmodule

// File: rtl/ps2_scan_receiver.sv
// PS/2 keyboard receiver: frames bytes off the filtered clock, checks odd parity
// and stop bit, folds F0/E0 prefixes into break/extended flags, and aborts stalled frames.
module ps2_scan_receiver
   import ps2_pkg::*;
#(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 100000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       ps2c,
   input  logic       ps2d,
   output logic [7:0] code,
   output logic       code_valid,
   output logic       key_break,
   output logic       key_ext,
   output logic       frame_err
);
   localparam int             WD_W     = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_MAX   = {WD_W{1'b1}};
   localparam logic [3:0]      LAST_BIT = 4'(FRAME_BITS - 2);

   logic                      fall_edge_s;
   logic [1:0]                dsync_r;
   logic                      ps2d_s;
   ps2_state_t                state_r, state_s;
   logic [3:0]                bit_cnt_r, bit_cnt_s;
   logic [FRAME_BITS-2:0]     frame_r, frame_s;
   logic [WD_W-1:0]           wd_r, wd_s;
   logic                      break_pend_r, break_pend_s;
   logic                      ext_pend_r, ext_pend_s;
   logic [7:0]                code_r, code_s;
   logic                      code_valid_r, code_valid_s;
   logic                      key_break_r, key_break_s;
   logic                      key_ext_r, key_ext_s;
   logic                      frame_err_r, frame_err_s;

   ps2_clk_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clk       (clk),
      .rst       (rst),
      .ps2c      (ps2c),
      .fall_edge (fall_edge_s)
   );

   assign ps2d_s = dsync_r[1];

   // State, datapath and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dsync_r      <= 2'b11;
         state_r      <= IDLE;
         bit_cnt_r    <= 4'd0;
         frame_r      <= '0;
         wd_r         <= '0;
         break_pend_r <= 1'b0;
         ext_pend_r   <= 1'b0;
         code_r       <= 8'h00;
         code_valid_r <= 1'b0;
         key_break_r  <= 1'b0;
         key_ext_r    <= 1'b0;
         frame_err_r  <= 1'b0;
      end else begin
         dsync_r      <= {dsync_r[0], ps2d};
         state_r      <= state_s;
         bit_cnt_r    <= bit_cnt_s;
         frame_r      <= frame_s;
         wd_r         <= wd_s;
         break_pend_r <= break_pend_s;
         ext_pend_r   <= ext_pend_s;
         code_r       <= code_s;
         code_valid_r <= code_valid_s;
         key_break_r  <= key_break_s;
         key_ext_r    <= key_ext_s;
         frame_err_r  <= frame_err_s;
      end
   end

   // Next-state, frame capture, watchdog and decode.
   always_comb begin
      state_s      = state_r;
      bit_cnt_s    = bit_cnt_r;
      frame_s      = frame_r;
      wd_s         = wd_r;
      break_pend_s = break_pend_r;
      ext_pend_s   = ext_pend_r;
      code_s       = code_r;
      key_break_s  = key_break_r;
      key_ext_s    = key_ext_r;
      code_valid_s = 1'b0;
      frame_err_s  = 1'b0;
      case (state_r)
         IDLE: begin
            wd_s = '0;
            if (fall_edge_s && !ps2d_s) begin
               state_s   = SHIFT;
               bit_cnt_s = 4'd0;
            end else begin
               state_s = IDLE;
            end
         end
         SHIFT: begin
            // An edge coinciding with watchdog expiry wins over the timeout.
            if (fall_edge_s) begin
               frame_s   = {ps2d_s, frame_r[FRAME_BITS-2:1]};
               wd_s      = '0;
               bit_cnt_s = bit_cnt_r + 4'd1;
               if (bit_cnt_r == LAST_BIT) begin
                  state_s = CHECK;
               end else begin
                  state_s = SHIFT;
               end
            end else if (wd_r >= WD_LIMIT) begin
               frame_err_s  = 1'b1;
               break_pend_s = 1'b0;
               ext_pend_s   = 1'b0;
               state_s      = IDLE;
            end else if (wd_r != WD_MAX) begin
               wd_s = wd_r + WD_W'(1);
            end else begin
               wd_s = wd_r;
            end
         end
         CHECK: begin
            state_s = IDLE;
            if (odd_parity_ok(frame_r[7:0], frame_r[8]) && frame_r[9]) begin
               if (frame_r[7:0] == BREAK_PREFIX) begin
                  break_pend_s = 1'b1;
               end else if (frame_r[7:0] == EXT_PREFIX) begin
                  ext_pend_s = 1'b1;
               end else begin
                  code_s       = frame_r[7:0];
                  key_break_s  = break_pend_r;
                  key_ext_s    = ext_pend_r;
                  code_valid_s = 1'b1;
                  break_pend_s = 1'b0;
                  ext_pend_s   = 1'b0;
               end
            end else begin
               frame_err_s  = 1'b1;
               break_pend_s = 1'b0;
               ext_pend_s   = 1'b0;
            end
         end
         default: begin
            state_s      = IDLE;
            break_pend_s = 1'b0;
            ext_pend_s   = 1'b0;
         end
      endcase
   end

   assign code       = code_r;
   assign code_valid = code_valid_r;
   assign key_break  = key_break_r;
   assign key_ext    = key_ext_r;
   assign frame_err  = frame_err_r;
endmodule
